// File: rtl/bf16_stage.sv
`default_nettype none
// ============================================================================
// Module      : bf16_stage
// Description : One radix-2 single-delay-feedback butterfly stage for a
//               32-point frame. A 16-entry complex delay line buffers the
//               first half of the frame. In FIRST it emits a+b and stores
//               a-b. In SECOND it emits the stored difference multiplied
//               by the twiddle WN.
// Ports       : clk, rst (async, active-low)
//               state_i            - phase: 00 IDLE, 11 WAITING,
//                                    01 FIRST, 10 SECOND
//               data_in_r/_i [DW]  - input sample, aligned with state_i
//               WN_r/_i      [WW]  - twiddle, Q2.8, used during SECOND
//               data_out_r/_i[DW+1]- registered stage result
//               valid_o            - data_out valid
//               out_idx [5]        - index of the output within the frame
//               last_o             - valid output with out_idx == 31
// Config      : BF16_ROUND_EN - round half up before the >>>8 of the
//               twiddle product (default: truncate toward -inf)
// Revision    : 1.0 - initial release
// ============================================================================
module bf16_stage #(
    parameter int DW = 19,
    parameter int WW = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           state_i,
    input  logic signed [DW-1:0] data_in_r,
    input  logic signed [DW-1:0] data_in_i,
    input  logic signed [WW-1:0] WN_r,
    input  logic signed [WW-1:0] WN_i,
    output logic signed [DW:0]   data_out_r,
    output logic signed [DW:0]   data_out_i,
    output logic                 valid_o,
    output logic [4:0]           out_idx,
    output logic                 last_o
);

    localparam int PW = DW + 1;       // delay-line / output width
    localparam int MW = PW + WW;      // single product width
    localparam int SW = MW + 1;       // sum of two products

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_WAIT   = 2'b11;
    localparam logic [1:0] S_FIRST  = 2'b01;
    localparam logic [1:0] S_SECOND = 2'b10;

`ifdef BF16_ROUND_EN
    localparam logic signed [SW-1:0] c_RND = SW'(128);
`else
    localparam logic signed [SW-1:0] c_RND = '0;
`endif
    localparam logic signed [SW-1:0] c_MAX = {{(WW+2){1'b0}}, {(PW-1){1'b1}}};
    localparam logic signed [SW-1:0] c_MIN = {{(WW+2){1'b1}}, {(PW-1){1'b0}}};

    logic signed [PW-1:0] r_dl_r [0:15];
    logic signed [PW-1:0] r_dl_i [0:15];
    logic [4:0]           r_cnt;

    logic signed [PW-1:0] w_head_r, w_head_i;
    logic signed [PW-1:0] w_b_r, w_b_i;
    logic signed [PW-1:0] w_g_r, w_g_i;
    logic signed [PW-1:0] w_push_r, w_push_i;
    logic signed [MW-1:0] w_hr_x, w_hi_x, w_wr_x, w_wi_x;
    logic signed [MW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [SW-1:0] w_sum_r, w_sum_i, w_rnd_r, w_rnd_i, w_sh_r, w_sh_i;
    logic signed [PW-1:0] w_m_r, w_m_i;

    // Oldest entry sits at index 15.
    assign w_head_r = r_dl_r[15];
    assign w_head_i = r_dl_i[15];
    assign w_b_r    = {data_in_r[DW-1], data_in_r};
    assign w_b_i    = {data_in_i[DW-1], data_in_i};
    assign w_g_r    = w_head_r + w_b_r;
    assign w_g_i    = w_head_i + w_b_i;

    // Operands are sign-extended to the full product width so the
    // multiplies are exact without relying on context extension.
    assign w_hr_x = {{WW{w_head_r[PW-1]}}, w_head_r};
    assign w_hi_x = {{WW{w_head_i[PW-1]}}, w_head_i};
    assign w_wr_x = {{PW{WN_r[WW-1]}}, WN_r};
    assign w_wi_x = {{PW{WN_i[WW-1]}}, WN_i};
    assign w_p_rr = w_hr_x * w_wr_x;
    assign w_p_ii = w_hi_x * w_wi_x;
    assign w_p_ri = w_hr_x * w_wi_x;
    assign w_p_ir = w_hi_x * w_wr_x;
    assign w_sum_r = {w_p_rr[MW-1], w_p_rr} - {w_p_ii[MW-1], w_p_ii};
    assign w_sum_i = {w_p_ri[MW-1], w_p_ri} + {w_p_ir[MW-1], w_p_ir};
    assign w_rnd_r = w_sum_r + c_RND;
    assign w_rnd_i = w_sum_i + c_RND;
    assign w_sh_r  = w_rnd_r >>> 8;
    assign w_sh_i  = w_rnd_i >>> 8;

    function automatic logic signed [PW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > c_MAX)      return c_MAX[PW-1:0];
        else if (v < c_MIN) return c_MIN[PW-1:0];
        else                return v[PW-1:0];
    endfunction

    assign w_m_r = sat(w_sh_r);
    assign w_m_i = sat(w_sh_i);

    always_comb begin
        w_push_r = '0;
        w_push_i = '0;
        case (state_i)
            S_WAIT: begin
                w_push_r = w_b_r;
                w_push_i = w_b_i;
            end
            S_FIRST: begin
                w_push_r = w_head_r - w_b_r;
                w_push_i = w_head_i - w_b_i;
            end
            default: ;
        endcase
    end

    // Delay line shifts in every non-IDLE phase and holds in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 16; k++) begin
                r_dl_r[k] <= '0;
                r_dl_i[k] <= '0;
            end
        end else if (state_i != S_IDLE) begin
            r_dl_r[0] <= w_push_r;
            r_dl_i[0] <= w_push_i;
            for (int k = 1; k < 16; k++) begin
                r_dl_r[k] <= r_dl_r[k-1];
                r_dl_i[k] <= r_dl_i[k-1];
            end
        end
    end

    // r_cnt is the index the next valid output will carry; it only
    // restarts on IDLE and otherwise wraps naturally at 32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_r <= '0;
            data_out_i <= '0;
            valid_o    <= 1'b0;
            last_o     <= 1'b0;
            out_idx    <= '0;
            r_cnt      <= '0;
        end else begin
            case (state_i)
                S_FIRST, S_SECOND: begin
                    data_out_r <= (state_i == S_FIRST) ? w_g_r : w_m_r;
                    data_out_i <= (state_i == S_FIRST) ? w_g_i : w_m_i;
                    valid_o    <= 1'b1;
                    last_o     <= (r_cnt == 5'd31);
                    out_idx    <= r_cnt;
                    r_cnt      <= r_cnt + 5'd1;
                end
                S_WAIT: begin
                    data_out_r <= '0;
                    data_out_i <= '0;
                    valid_o    <= 1'b0;
                    last_o     <= 1'b0;
                end
                default: begin
                    data_out_r <= '0;
                    data_out_i <= '0;
                    valid_o    <= 1'b0;
                    last_o     <= 1'b0;
                    out_idx    <= '0;
                    r_cnt      <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bf16_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf16_stage
// Description : Randomized self-checking bench for bf16_stage with a
//               queue-based behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bf16_stage;

    localparam int DW = 19;
    localparam int WW = 10;
    localparam int PW = DW + 1;

    localparam logic [1:0] IDLE = 2'b00, WAIT = 2'b11, FIRST = 2'b01, SECOND = 2'b10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [1:0]           state_i = IDLE;
    logic signed [DW-1:0] din_r = '0, din_i = '0;
    logic signed [WW-1:0] wn_r = '0, wn_i = '0;
    logic signed [PW-1:0] dout_r, dout_i;
    logic                 valid_o, last_o;
    logic [4:0]           out_idx;

    bf16_stage #(.DW(DW), .WW(WW)) dut (
        .clk(clk), .rst(rst), .state_i(state_i),
        .data_in_r(din_r), .data_in_i(din_i),
        .WN_r(wn_r), .WN_i(wn_i),
        .data_out_r(dout_r), .data_out_i(dout_i),
        .valid_o(valid_o), .out_idx(out_idx), .last_o(last_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a FIFO of the 16 most recently stored values.
    longint q_r[$];
    longint q_i[$];
    int     m_cnt;

    task automatic model_clear();
        q_r.delete();
        q_i.delete();
        for (int k = 0; k < 16; k++) begin
            q_r.push_back(0);
            q_i.push_back(0);
        end
        m_cnt = 0;
    endtask

    function automatic longint clamp(input longint v);
        longint hi = (longint'(1) <<< DW) - 1;
        longint lo = -(longint'(1) <<< DW);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint scale(input longint v);
`ifdef BF16_ROUND_EN
        return clamp((v + 128) >>> 8);
`else
        return clamp(v >>> 8);
`endif
    endfunction

    task automatic step(input logic [1:0] st, input longint xr, input longint xi,
                        input longint wr, input longint wi);
        longint hr, hi, er, ei, pr, pi;
        bit     ev;
        int     eidx;
        er = 0; ei = 0; ev = 1'b0; eidx = 0;
        state_i = st;
        din_r   = DW'(xr);
        din_i   = DW'(xi);
        wn_r    = WW'(wr);
        wn_i    = WW'(wi);
        hr = q_r[0];
        hi = q_i[0];
        pr = 0; pi = 0;
        case (st)
            IDLE: m_cnt = 0;
            WAIT: begin pr = xr; pi = xi; end
            FIRST: begin
                er = hr + xr; ei = hi + xi;
                pr = hr - xr; pi = hi - xi;
                ev = 1'b1;
            end
            default: begin
                er = scale(hr * wr - hi * wi);
                ei = scale(hr * wi + hi * wr);
                ev = 1'b1;
            end
        endcase
        if (st != IDLE) begin
            void'(q_r.pop_front());
            void'(q_i.pop_front());
            q_r.push_back(pr);
            q_i.push_back(pi);
        end
        if (ev) begin
            eidx  = m_cnt;
            m_cnt = (m_cnt + 1) % 32;
        end
        @(posedge clk);
        #1;
        check("valid", valid_o, ev);
        check("dout_r", dout_r, er);
        check("dout_i", dout_i, ei);
        if (ev || st == IDLE) check("out_idx", out_idx, eidx);
        check("last", last_o, (ev && eidx == 31) ? 1 : 0);
    endtask

    longint fx_r[32], fx_i[32], fw_r[16], fw_i[16];
    int tw_r[16] = '{256, 237, 181, 98, 0, -98, -181, -237, -256, -237, -181, -98, 0, 98, 181, 237};
    int tw_i[16] = '{0, -98, -181, -237, -256, -237, -181, -98, 0, 98, 181, 237, 256, 237, 181, 98};

    function automatic longint rnd_s(input int w);
        longint v;
        v = longint'($urandom_range(0, (1 << w) - 1));
        if (v >= (longint'(1) <<< (w - 1))) v = v - (longint'(1) <<< w);
        return v;
    endfunction

    task automatic run_frame();
        for (int n = 0; n < 16; n++) step(WAIT, fx_r[n], fx_i[n], 0, 0);
        for (int n = 0; n < 16; n++) step(FIRST, fx_r[n+16], fx_i[n+16], 0, 0);
        for (int k = 0; k < 16; k++) step(SECOND, rnd_s(DW), rnd_s(DW), fw_r[k], fw_i[k]);
    endtask

    task automatic fill(input longint ar, input longint ai, input longint br, input longint bi,
                        input longint wr, input longint wi, input bit use_tw);
        for (int n = 0; n < 16; n++) begin
            fx_r[n] = ar; fx_i[n] = ai; fx_r[n+16] = br; fx_i[n+16] = bi;
            fw_r[n] = use_tw ? longint'(tw_r[n]) : wr;
            fw_i[n] = use_tw ? longint'(tw_i[n]) : wi;
        end
    endtask

    initial begin
        model_clear();
        #22;
        check("rst_valid", valid_o, 0);
        check("rst_dout_r", dout_r, 0);
        check("rst_idx", out_idx, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int n = 0; n < 3; n++) step(IDLE, rnd_s(DW), rnd_s(DW), 0, 0);

        // DC frame
        fill(1000, 0, 1000, 0, 0, 0, 1'b1);
        run_frame();
        step(IDLE, 0, 0, 0, 0);

        // Twiddle frame: zeros then 256, standard twiddle table
        fill(0, 0, 256, 0, 0, 0, 1'b1);
        run_frame();

        // Rounding frame: head=(1,0), WN=(236,-98)
        fill(1, 0, 0, 0, 236, -98, 1'b0);
        run_frame();

        // Saturation frame
        fill(-262144, -262144, 262143, 262143, 181, 181, 1'b0);
        run_frame();
        step(IDLE, 0, 0, 0, 0);

        // Random frames back to back so out_idx wraps without IDLE
        for (int f = 0; f < 6; f++) begin
            for (int n = 0; n < 32; n++) begin
                fx_r[n] = rnd_s(DW); fx_i[n] = rnd_s(DW);
            end
            for (int k = 0; k < 16; k++) begin
                fw_r[k] = (f < 3) ? longint'(tw_r[k]) : rnd_s(WW);
                fw_i[k] = (f < 3) ? longint'(tw_i[k]) : rnd_s(WW);
            end
            run_frame();
        end

        // Abort after 5 FIRST cycles, then a clean DC frame
        step(IDLE, 0, 0, 0, 0);
        for (int n = 0; n < 16; n++) step(WAIT, rnd_s(DW), rnd_s(DW), 0, 0);
        for (int n = 0; n < 5; n++) step(FIRST, rnd_s(DW), rnd_s(DW), 0, 0);
        step(IDLE, 0, 0, 0, 0);
        step(IDLE, 0, 0, 0, 0);
        fill(1000, 0, 1000, 0, 0, 0, 1'b1);
        run_frame();

        // Asynchronous reset mid-frame
        for (int n = 0; n < 16; n++) step(WAIT, rnd_s(DW), rnd_s(DW), 0, 0);
        for (int n = 0; n < 3; n++) step(FIRST, rnd_s(DW), rnd_s(DW), 0, 0);
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_dout_r", dout_r, 0);
        check("arst_dout_i", dout_i, 0);
        check("arst_idx", out_idx, 0);
        check("arst_last", last_o, 0);
        state_i = IDLE;
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int n = 0; n < 3; n++) step(IDLE, rnd_s(DW), rnd_s(DW), 0, 0);
        fill(1000, 0, 1000, 0, 0, 0, 1'b1);
        run_frame();
        step(IDLE, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bf16_stage.md
BF16_STAGE -- requirements
Module: bf16_stage

Interface
REQ-001 The block SHALL have parameter DW, default 19: input sample width per component, signed.
REQ-002 The block SHALL have parameter WW, default 10: twiddle width per component, signed Q2.8.
REQ-003 The block SHALL have port clk, input, 1: clock; all registers update on rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset; asynchronous, active-low.
REQ-005 The block SHALL have port state_i, input, 2: phase from stage controller (00 IDLE, 11 WAITING, 01 FIRST, 10 SECOND).
REQ-006 The block SHALL have ports data_in_r and data_in_i, input, DW each: sample aligned with state_i in the same cycle.
REQ-007 The block SHALL have ports WN_r and WN_i, input, WW each: twiddle exp(-j2πk/16), valid during SECOND.
REQ-008 The block SHALL have ports data_out_r and data_out_i, output, DW+1 each: stage result, registered.
REQ-009 The block SHALL have port valid_o, output, 1: data_out valid.
REQ-010 The block SHALL have port out_idx, output, 5: index 0..31 of the current output sample within the frame.
REQ-011 The block SHALL have port last_o, output, 1: high with out_idx==31.

Function
REQ-012 The block SHALL contain a 16-entry complex delay line of DW+1 bits per component, shifting one entry per cycle in WAITING, FIRST and SECOND, and holding in IDLE.
REQ-013 In WAITING, the block SHALL push the sign-extended data_in into the delay line and SHALL keep valid_o=0.
REQ-014 In FIRST, with a = delay-line head and b = data_in, the block SHALL output g = a+b (full DW+1 width, no overflow possible) and SHALL push h = a-b into the delay line.
REQ-015 In SECOND, the block SHALL output head×WN (complex multiply), SHALL push zero into the delay line, and SHALL ignore data_in.
REQ-016 The product SHALL be computed per component as (DW+1)×WW → DW+WW+1 bits, summed, scaled by an arithmetic shift right of 8, and saturated to DW+1 bits (max 2^DW-1, min -2^DW).
REQ-017 Latency SHALL be one cycle: a result computed in a cycle with state_i FIRST or SECOND appears on data_out, with valid_o=1, at the next rising edge.
REQ-018 Outside valid cycles, data_out SHALL be driven to 0.
REQ-019 out_idx SHALL be 0 at the first FIRST output and SHALL increment per valid output through 31; on the following valid output it SHALL wrap to 0; on any IDLE cycle it SHALL return to 0.
REQ-020 last_o SHALL be high for exactly the one cycle in which out_idx==31 and valid_o==1.
REQ-021 state_i returning to IDLE mid-frame SHALL abort the frame: valid_o=0 on the next cycle, out_idx=0, and the delay-line contents are don't-care for the next frame, which re-fills in WAITING.

Reset
REQ-022 While rst=0, the block SHALL clear data_out_r, data_out_i, out_idx, valid_o, last_o and all delay-line entries to 0, independent of clk.
REQ-023 After rst is released, the block SHALL take no action until state_i leaves IDLE.

Configuration
REQ-024 The block SHALL support macro BF16_ROUND_EN: when it is defined, 2^7 SHALL be added before the shift of REQ-016 (round half up); when it is undefined, the shift SHALL truncate toward -∞. FIRST-phase outputs are unaffected either way.

Verification
REQ-025 Reset test: assert rst=0 mid-frame -> all outputs 0 immediately; after release with IDLE, valid_o stays 0.
REQ-026 DC test: all 32 samples = (1000,0) -> 16 outputs (2000,0), then 16 outputs (0,0); out_idx 0..31; last_o on the 32nd output only.
REQ-027 Twiddle test: x[0..15]=0, x[16..31]=(256,0) -> FIRST outputs (256,0); SECOND output at k=4 with WN=(0,-256) gives (0,256).
REQ-028 Rounding test: head=(1,0) with WN=(236,-98) -> (1,0) with BF16_ROUND_EN defined; (0,-1) with it undefined.
REQ-029 Saturation test: x[n]=(-262144,-262144), x[n+16]=(262143,262143), WN=(181,181) -> SECOND output (0,-524288).
REQ-030 Abort test: state_i forced to IDLE after 5 FIRST cycles -> valid_o low the next cycle; a full following frame gives correct results per REQ-026.
